accumulation_seq: RTL and testbench
===================================

# accumulation_seq

Multi-cycle sequencer for the binary-net XNOR accumulation stage. It streams a neuron's XNOR product bits in fixed-width chunks from the upstream activation/weight buffer and accumulates the ±1 contributions in a signed register. Each neuron's sum is saturated to a PARAM_IN_BIT-bit signed result and emitted over a valid/ready handshake, one neuron after another, until PARAM_OUT_CNT neurons are done. It sits between the XNOR array and the next layer's activation buffer, replacing the fully parallel single-cycle sum when area matters.

## Interface
- PARAM_IN_CNT, 784, inputs per neuron
- PARAM_IN_BIT, 2, signed result width (≥2)
- PARAM_CH_CNT, 2**PARAM_IN_BIT, XNOR bits per input
- PARAM_CHUNK, 16, inputs consumed per beat
- PARAM_OUT_CNT, 10, neurons per layer pass
- Derived: BEATS = ceil(PARAM_IN_CNT/PARAM_CHUNK); ACC_W = $clog2(PARAM_IN_CNT*PARAM_CH_CNT)+1 (signed)

- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  begin a layer pass; sampled only in IDLE
- abort_i  in  1  synchronous return to IDLE, no done_o
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse after the last neuron's result is accepted
- chunk_valid_i  in  1  chunk data valid
- chunk_ready_o  out  1  high only in ACCUM
- xnor_i  in  [PARAM_CHUNK-1:0][PARAM_CH_CNT-1:0]  XNOR bits for the current beat; 1 = +1, 0 = −1
- beat_idx_o  out  $clog2(BEATS)  index of the beat requested next
- neuron_idx_o  out  $clog2(PARAM_OUT_CNT)  neuron being processed
- result_valid_o  out  1  high in EMIT
- result_ready_i  in  1  downstream accepts result
- result_o  out  PARAM_IN_BIT  saturated signed result

## Operation
- States: IDLE, ACCUM, EMIT.
- IDLE
  - start_i=1: clear acc, beat_idx, neuron_idx; go to ACCUM.
  - start_i while busy_o=1 is ignored.
- ACCUM
  - A beat transfers when chunk_valid_i & chunk_ready_o. On each transfer: acc += 2·popcount(masked bits) − (masked bit count); beat_idx increments.
  - Masking applies to the last beat only. Inputs with index beat·PARAM_CHUNK+k ≥ PARAM_IN_CNT contribute 0, whatever their value.
  - When the transfer on beat BEATS−1 completes, register result_o = sat(acc_next) and go to EMIT.
- Saturation
  - Clamp to [−2^(B−1), 2^(B−1)−1]; for B=2 that is [−2, +1].
  - Sign-extended comparison over the full ACC_W width; two's-complement output.
- EMIT
  - result_valid_o=1; result_o is held stable until accepted.
  - On result_ready_i, if neuron_idx = PARAM_OUT_CNT−1: go to IDLE and pulse done_o in the following cycle.
  - Otherwise: neuron_idx++, clear acc and beat_idx, go to ACCUM.
- abort_i has priority over every transition in ACCUM and EMIT. Next state is IDLE, all counters clear, no done_o pulse.
- Accumulator cannot overflow: |acc| ≤ PARAM_IN_CNT·PARAM_CH_CNT < 2^(ACC_W−1).

## Timing
- Reset values: busy_o=0, done_o=0, chunk_ready_o=0, result_valid_o=0, result_o=0, beat_idx_o=0, neuron_idx_o=0, state IDLE.
- Reset takes effect immediately, including mid-operation. After rst_i deasserts, nothing happens until a new start_i.
- start_i at cycle 0 gives busy_o=1 and chunk_ready_o=1 at cycle 1.
- With continuous valid/ready, each neuron takes BEATS+1 cycles (BEATS accumulate + 1 emit).
- Default parameters: 10·(49+1)=500 cycles; done_o is high at cycle 501 after start.
- chunk_ready_o and result_valid_o are never high in the same cycle.
- Stalls: chunk_valid_i=0 freezes acc and beat_idx. result_ready_i=0 holds EMIT and result_o.
- beat_idx_o and neuron_idx_o are registered and point at the data required in the current cycle.

## Test plan
- All-ones xnor_i, default params, continuous handshake -> acc=+3136 per neuron; ten results 2'b01; done_o high exactly once, 501 cycles after start_i.
- All-zeros xnor_i -> acc=−3136; ten results 2'b10.
- Beat 0 has 31 ones of 64, all other beats 32 of 64 -> acc=−2 -> result 2'b10. Beat 0 with 32 ones -> acc=0 -> 2'b00.
- PARAM_IN_CNT=20, PARAM_CHUNK=16, PARAM_OUT_CNT=2
  - Beat 1 valid inputs all zero, masked inputs all ones -> acc=−80 -> 2'b10; masked bits have no effect.
  - All ones on every beat -> acc=+80 -> 2'b01.
- Random chunk_valid_i gaps, plus result_ready_i held low 5 cycles in EMIT -> result_o stable, chunk_ready_o=0, no beats consumed; results match the no-stall run.
- rst_i at beat 20 of neuron 3 -> all outputs at reset values the same cycle. abort_i in EMIT -> IDLE next cycle, no done_o. start_i while busy_o -> ignored.

Source files
------------

// File: rtl/accumulation_seq.sv
// Chunked XNOR +/-1 accumulator with per-neuron saturation.
// Streams BEATS chunks per neuron and emits one signed result per neuron.
module accumulation_seq #(
  parameter  int PARAM_IN_CNT  = 784,
  parameter  int PARAM_IN_BIT  = 2,
  parameter  int PARAM_CH_CNT  = 2**PARAM_IN_BIT,
  parameter  int PARAM_CHUNK   = 16,
  parameter  int PARAM_OUT_CNT = 10,
  localparam int BEATS = (PARAM_IN_CNT + PARAM_CHUNK - 1) / PARAM_CHUNK,
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int NW    = (PARAM_OUT_CNT > 1) ? $clog2(PARAM_OUT_CNT) : 1,
  localparam int ACC_W = $clog2(PARAM_IN_CNT * PARAM_CH_CNT) + 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   start_i,
  input  logic                                   abort_i,
  output logic                                   busy_o,
  output logic                                   done_o,
  input  logic                                   chunk_valid_i,
  output logic                                   chunk_ready_o,
  input  logic [PARAM_CHUNK-1:0][PARAM_CH_CNT-1:0] xnor_i,
  output logic [BW-1:0]                          beat_idx_o,
  output logic [NW-1:0]                          neuron_idx_o,
  output logic                                   result_valid_o,
  input  logic                                   result_ready_i,
  output logic [PARAM_IN_BIT-1:0]                result_o
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT
  } state_e;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [NW-1:0] LAST_NRN  = NW'(PARAM_OUT_CNT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    ACC_W'(2**(PARAM_IN_BIT-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  state_e state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] delta, acc_sum;
  logic [BW-1:0] beat_q, beat_d;
  logic [NW-1:0] neuron_q, neuron_d;
  logic [PARAM_IN_BIT-1:0] result_q, result_d;
  logic [PARAM_IN_BIT-1:0] sat_val;
  logic done_q, done_d;

  // Inputs past PARAM_IN_CNT on the final beat add nothing.
  always_comb begin
    delta = '0;
    for (int k = 0; k < PARAM_CHUNK; k++) begin
      if (int'(beat_q) * PARAM_CHUNK + k < PARAM_IN_CNT) begin
        for (int c = 0; c < PARAM_CH_CNT; c++) begin
          if (xnor_i[k][c]) delta = delta + ACC_W'(1);
          else              delta = delta - ACC_W'(1);
        end
      end
    end
  end

  always_comb begin
    acc_sum = acc_q + delta;
    sat_val = acc_sum[PARAM_IN_BIT-1:0];
    if (acc_sum > SAT_MAX) begin
      sat_val = SAT_MAX[PARAM_IN_BIT-1:0];
    end else if (acc_sum < SAT_MIN) begin
      sat_val = SAT_MIN[PARAM_IN_BIT-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    beat_d   = beat_q;
    neuron_d = neuron_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (abort_i) begin
      state_d  = IDLE;
      acc_d    = '0;
      beat_d   = '0;
      neuron_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d  = ACCUM;
            acc_d    = '0;
            beat_d   = '0;
            neuron_d = '0;
          end
        end
        ACCUM: begin
          if (chunk_valid_i) begin
            acc_d = acc_sum;
            if (beat_q == LAST_BEAT) begin
              beat_d   = '0;
              result_d = sat_val;
              state_d  = EMIT;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
        EMIT: begin
          if (result_ready_i) begin
            acc_d  = '0;
            beat_d = '0;
            if (neuron_q == LAST_NRN) begin
              state_d  = IDLE;
              neuron_d = '0;
              done_d   = 1'b1;
            end else begin
              neuron_d = neuron_q + 1'b1;
              state_d  = ACCUM;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      beat_q   <= '0;
      neuron_q <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      beat_q   <= beat_d;
      neuron_q <= neuron_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy_o         = (state_q != IDLE);
  assign chunk_ready_o  = (state_q == ACCUM);
  assign result_valid_o = (state_q == EMIT);
  assign done_o         = done_q;
  assign beat_idx_o     = beat_q;
  assign neuron_idx_o   = neuron_q;
  assign result_o       = result_q;

endmodule

// File: tb/tb_accumulation_seq.sv
// Scoreboard bench for accumulation_seq: default and small-mask instances.
// Expected results come from a flat-bit sum model with clamping.
module tb_accumulation_seq;

  logic clk = 1'b0;
  logic rst_i;
  logic start_i, abort_i, chunk_valid_i, result_ready_i;
  logic [15:0][3:0] xnor_i;
  logic busy_o, done_o, chunk_ready_o, result_valid_o;
  logic [5:0] beat_idx_o;
  logic [3:0] neuron_idx_o;
  logic [1:0] result_o;

  logic s_start, s_valid, s_rready;
  logic [15:0][3:0] s_xnor;
  logic s_busy, s_done, s_cready, s_rvalid;
  logic [0:0] s_bidx, s_nidx;
  logic [1:0] s_res;

  int n_pass = 0;
  int n_tot = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int n0 = 0;
  bit mon_en = 1'b1;
  bit man_rdy = 1'b1;
  bit stall_en = 1'b0;
  bit rdy_rand = 1'b0;
  logic [1:0] exp_q[$];

  accumulation_seq u_dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o),
    .chunk_valid_i(chunk_valid_i), .chunk_ready_o(chunk_ready_o),
    .xnor_i(xnor_i), .beat_idx_o(beat_idx_o),
    .neuron_idx_o(neuron_idx_o), .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i), .result_o(result_o)
  );

  accumulation_seq #(
    .PARAM_IN_CNT(20), .PARAM_CHUNK(16), .PARAM_OUT_CNT(2)
  ) u_small (
    .clk_i(clk), .rst_i(rst_i), .start_i(s_start), .abort_i(1'b0),
    .busy_o(s_busy), .done_o(s_done),
    .chunk_valid_i(s_valid), .chunk_ready_o(s_cready),
    .xnor_i(s_xnor), .beat_idx_o(s_bidx),
    .neuron_idx_o(s_nidx), .result_valid_o(s_rvalid),
    .result_ready_i(s_rready), .result_o(s_res)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done_o) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic fail(input string nm);
    n_tot++;
    $display("FAIL %s: event missing (t=%0t)", nm, $time);
  endtask

  // Sum of +/-1 over the first nbits flat bits, clamped to 2-bit signed.
  function automatic logic [1:0] ref_res(input logic [3135:0] d, input int nbits);
    int s = 0;
    for (int i = 0; i < nbits; i++) s += d[i] ? 1 : -1;
    if (s > 1) return 2'b01;
    if (s < -2) return 2'b10;
    return s[1:0];
  endfunction

  task automatic gen(output logic [3135:0] nd, input int mode);
    logic [31:0] w;
    int k;
    bit hit;
    nd = '0;
    case (mode)
      0: nd = '1;
      1: nd = '0;
      2: begin
        for (int b = 0; b < 49; b++) begin
          w = $urandom;
          nd[b*64 +: 64] = {w, ~w};
        end
        k = $urandom_range(0, 2);
        hit = 1'b0;
        for (int i = 0; i < 64; i++) begin
          if (!hit && k == 0 && nd[i]) begin nd[i] = 1'b0; hit = 1'b1; end
          if (!hit && k == 2 && !nd[i]) begin nd[i] = 1'b1; hit = 1'b1; end
        end
      end
      default: begin
        for (int b = 0; b < 49; b++) nd[b*64 +: 64] = {$urandom, $urandom};
      end
    endcase
  endtask

  task automatic run_pass(input int mode, input bit gaps, input bit timing);
    logic [3135:0] nd;
    int t, d0;
    bit got;
    d0 = done_cnt;
    @(negedge clk);
    start_i = 1'b1;
    n0 = cyc;
    @(negedge clk);
    start_i = 1'b0;
    for (int j = 0; j < 10; j++) begin
      gen(nd, mode);
      exp_q.push_back(ref_res(nd, 3136));
      for (int b = 0; b < 49; b++) begin
        got = 1'b0;
        t = 0;
        while (!got && t < 200) begin
          chunk_valid_i = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
          xnor_i = nd[b*64 +: 64];
          if (chunk_valid_i && chunk_ready_o) begin
            chk("beat_idx", beat_idx_o, b);
            chk("neuron_idx", neuron_idx_o, j);
            got = 1'b1;
          end
          @(negedge clk);
          t++;
        end
        if (!got) fail("beat_timeout");
      end
    end
    chunk_valid_i = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
    if (timing) chk("done_cycle", done_cyc - n0, 501);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  // Result monitor: optional ready stalls, then pops and compares.
  initial begin
    result_ready_i = 1'b1;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        result_ready_i = man_rdy;
      end else if (result_valid_o) begin
        int d;
        logic [1:0] held;
        logic [1:0] e;
        chk("ready_valid_excl", chunk_ready_o, 0);
        d = stall_en ? 5 : (rdy_rand ? $urandom_range(0, 3) : 0);
        held = result_o;
        if (d > 0) begin
          result_ready_i = 1'b0;
          repeat (d) begin
            @(negedge clk);
            chk("stall_result", result_o, held);
            chk("stall_valid", result_valid_o, 1);
            chk("stall_chunk_rdy", chunk_ready_o, 0);
          end
        end
        result_ready_i = 1'b1;
        if (exp_q.size() == 0) fail("sb_underflow");
        else begin
          e = exp_q.pop_front();
          chk("result", result_o, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1);
  end

  initial begin
    logic [127:0] sd [2];
    logic [3135:0] tmp;
    logic [1:0] se;
    int t, d0;
    rst_i = 1'b1;
    start_i = 1'b0;
    abort_i = 1'b0;
    chunk_valid_i = 1'b0;
    xnor_i = '0;
    s_start = 1'b0;
    s_valid = 1'b0;
    s_rready = 1'b1;
    s_xnor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_chunk_rdy", chunk_ready_o, 0);
    chk("rst_rvalid", result_valid_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_beat", beat_idx_o, 0);
    chk("rst_neuron", neuron_idx_o, 0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy_o, 0);

    run_pass(0, 1'b0, 1'b1);
    run_pass(1, 1'b0, 1'b1);
    stall_en = 1'b1;
    run_pass(2, 1'b0, 1'b0);
    run_pass(2, 1'b1, 1'b0);
    stall_en = 1'b0;
    rdy_rand = 1'b1;
    run_pass(3, 1'b1, 1'b0);
    run_pass(2, 1'b1, 1'b0);
    rdy_rand = 1'b0;

    // Reset mid-run: neuron 3, beat 20
    mon_en = 1'b0;
    man_rdy = 1'b1;
    xnor_i = '1;
    chunk_valid_i = 1'b1;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("start_busy", busy_o, 1);
    chk("start_chunk_rdy", chunk_ready_o, 1);
    repeat (170) @(negedge clk);
    chk("mid_neuron", neuron_idx_o, 3);
    chk("mid_beat", beat_idx_o, 20);
    #1 rst_i = 1'b1;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_chunk_rdy", chunk_ready_o, 0);
    chk("arst_rvalid", result_valid_o, 0);
    chk("arst_result", result_o, 0);
    chk("arst_beat", beat_idx_o, 0);
    chk("arst_neuron", neuron_idx_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", busy_o, 0);
    chk("post_rst_chunk", chunk_ready_o, 0);

    // Start while busy ignored; abort in EMIT
    man_rdy = 1'b0;
    xnor_i = {$urandom, $urandom};
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    chk("busy_beat_before", beat_idx_o, 9);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("start_ignored_beat", beat_idx_o, 10);
    chk("start_ignored_busy", busy_o, 1);
    t = 0;
    while (!result_valid_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("emit_reached", result_valid_o, 1);
    chk("emit_cycle", t, 39);
    repeat (2) @(negedge clk);
    chk("emit_held", result_valid_o, 1);
    d0 = done_cnt;
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chunk_valid_i = 1'b0;
    chk("abort_busy", busy_o, 0);
    chk("abort_rvalid", result_valid_o, 0);
    chk("abort_neuron", neuron_idx_o, 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);

    // Masked last beat on the small instance
    sd[0] = '0;
    sd[0][127:80] = '1;
    sd[1] = '1;
    s_valid = 1'b1;
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int nn = 0; nn < 2; nn++) begin
      tmp = '0;
      tmp[127:0] = sd[nn];
      se = ref_res(tmp, 80);
      s_xnor = sd[nn][63:0];
      chk("s_chunk_rdy", s_cready, 1);
      chk("s_beat0", s_bidx, 0);
      chk("s_neuron", s_nidx, nn);
      @(negedge clk);
      s_xnor = sd[nn][127:64];
      chk("s_beat1", s_bidx, 1);
      @(negedge clk);
      chk("s_rvalid", s_rvalid, 1);
      chk("s_excl", s_cready, 0);
      chk("s_result", s_res, se);
      @(negedge clk);
    end
    chk("s_done", s_done, 1);
    chk("s_idle", s_busy, 0);
    s_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
